decoder_scan_sequencer: RTL and testbench
=========================================

Name: decoder_scan_sequencer

Overview:
- Upstream driver for the 3-to-8 decoder. It steps a 3-bit channel index from 0 to a programmable last channel.
- Each channel is held on the decoder select lines (a, b, c) with enable high for a programmable dwell time.
- Between channels, enable is blanked low for a fixed gap so that two decoder outputs are never active together.
- Supports a single pass (done pulse at the end) or continuous wrap-around scanning. Used for scanning 8 one-hot loads such as display digits or bank strobes.

Parameters:
- DWELL_W, 8, width of the dwell-count input.
- GAP_CYCLES, 1, number of blanking cycles with enable=0 between channels; 0 is legal and means no blanking.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
- stop  input  1  abort; takes effect from any state.
- continuous  input  1  1 = wrap from last channel back to 0; 0 = single pass. Sampled at start.
- last_ch  input  3  highest channel index to scan (0..7). Sampled at start.
- dwell  input  DWELL_W  cycles each channel is held. Sampled at start; 0 is treated as 1.
- a  output  1  decoder select bit 0 (index[0]).
- b  output  1  decoder select bit 1 (index[1]).
- c  output  1  decoder select bit 2 (index[2]).
- enable  output  1  decoder enable; high only in SCAN.
- channel  output  3  current index, equal to {c,b,a}.
- busy  output  1  high in SCAN and GAP.
- done  output  1  one-cycle pulse at the end of a single pass.

Behaviour:
- All outputs are registered.
  - On reset: a=b=c=0, channel=0, enable=0, busy=0, done=0, state=IDLE, dwell counter=0, gap counter=0.
  - Reset is honoured asynchronously in any state, including mid-dwell.
- States are IDLE, SCAN, GAP and DONE, encoded in 2 bits.
- IDLE:
  - enable=0, busy=0.
  - start=1 and stop=0: latch last_ch, continuous and max(dwell,1). Set channel=0. Load the dwell counter with the latched dwell-1. Next cycle the state is SCAN with enable=1.
  - Latency is one cycle from start to the first enable.
  - start and stop both high in the same cycle: stop wins and the block stays in IDLE.
- SCAN:
  - enable=1 and channel is stable for exactly the latched dwell number of cycles.
  - The counter decrements each cycle.
  - When the counter reaches 0 and channel < last_ch_latched: go to GAP (or, if GAP_CYCLES=0, stay in SCAN with channel+1 and the counter reloaded).
  - When the counter reaches 0 and channel == last_ch_latched:
    - If continuous: go to GAP, then channel wraps to 0.
    - Otherwise: go to DONE.
- GAP:
  - enable=0 and busy=1 for GAP_CYCLES cycles.
  - channel changes on entry to GAP, not on exit. The select lines therefore settle while enable is low.
  - Then go to SCAN with the dwell counter reloaded.
- DONE:
  - done=1 and enable=0 for one cycle; channel holds last_ch.
  - Then go to IDLE. start during DONE is ignored.
- start while busy: ignored. Latched parameters never change mid-scan.
- stop in SCAN, GAP or DONE: next cycle the state is IDLE, enable=0, busy=0, no done pulse, and channel returns to 0.
- last_ch=0: scans channel 0 only. In continuous mode it loops channel 0 with a GAP between dwells (or enable stays high continuously if GAP_CYCLES=0).
- The counters are sized DWELL_W and clog2(GAP_CYCLES+1) with a minimum of 1. No overflow is possible because counters only count down from loaded values.
- enable is never high in two consecutive cycles with different channel values unless GAP_CYCLES=0.

Decomposition:
- A shared package or include holds the state encodings (ST_IDLE=2'd0, ST_SCAN=2'd1, ST_GAP=2'd2, ST_DONE=2'd3) and the channel width constant CH_W=3.
- One natural sub-module: scan_down_counter, a loadable down-counter with a zero flag. It is instantiated twice, once for dwell and once for gap.
- The top level contains the FSM, the latched configuration and the output registers.
- A bench-level integration instantiates decoder_scan_sequencer feeding decoder_3_to_8.

Test Plan:
- Single pass with last_ch=2, dwell=3, GAP_CYCLES=1, continuous=0, start pulse -> enable high for 3 cycles on each of channels 0, 1 and 2, with one enable=0 cycle between them. done pulses once, 1 cycle after channel 2's dwell ends. Total 12 cycles from start to done. Decoder outputs y0, y1 and y2 each pulse 3 cycles.
- Continuous mode with last_ch=7, dwell=1 -> channel sequence 0..7,0,1,... with enable alternating 1/0. done is never asserted. busy stays 1.
- dwell=0 and last_ch=0 -> behaves exactly as dwell=1: one enable cycle on channel 0, then done.
- stop asserted during the 2nd dwell cycle of channel 4 -> next cycle enable=0, busy=0, channel=0, no done pulse. A subsequent start restarts from channel 0.
- reset asserted asynchronously mid-GAP, deasserted 2 cycles later -> outputs go to their reset values immediately. A start after reset gives normal operation.
- start held high throughout a scan, and start+stop pulsed together in IDLE -> the repeated start is ignored while busy, and start+stop in IDLE leaves the block in IDLE.

Source files
------------

// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM state encoding
// and the width of the decoder channel index.
package decoder_scan_sequencer_pkg;

    localparam int CH_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/decoder_scan_sequencer_scan_down_counter.sv
// Loadable down-counter with a zero flag. Load has priority over decrement,
// and the count parks at zero instead of wrapping.
module scan_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Count register: load a new value or step down towards zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving a 3-to-8 decoder: steps the channel index from 0 to
// a latched last channel, holds each channel with enable high for a latched
// dwell, and blanks enable for GAP_CYCLES between channels.
module decoder_scan_sequencer
    import decoder_scan_sequencer_pkg::*;
#(
    parameter int DWELL_W    = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [CH_W-1:0]    last_ch,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               enable,
    output logic [CH_W-1:0]    channel,
    output logic               busy,
    output logic               done
);

    localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    state_t             state;
    logic [CH_W-1:0]    last_q;
    logic               cont_q;
    logic [DWELL_W-1:0] dwell_m1_q;

    logic [DWELL_W-1:0] dwell_in_m1;
    logic               launch;
    logic               dwell_end;
    logic               at_last;
    logic               advance;
    logic               gap_end;
    logic [CH_W-1:0]    next_ch;

    logic               dwell_load;
    logic [DWELL_W-1:0] dwell_val;
    logic               dwell_dec;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_zero;

    logic               gap_load;
    logic               gap_dec;
    logic [GAP_W-1:0]   gap_cnt;
    logic               gap_zero;

    // Sequencing decisions and counter controls for the current cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        dwell_in_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        launch      = (state == ST_IDLE) && start && !stop;
        dwell_end   = (state == ST_SCAN) && !stop && dwell_zero;
        at_last     = (channel == last_q);
        advance     = dwell_end && (!at_last || cont_q);
        gap_end     = (state == ST_GAP) && !stop && gap_zero;
        next_ch     = at_last ? '0 : channel + CH_W'(1);

        dwell_load  = launch || (advance && !HAS_GAP) || gap_end;
        dwell_val   = launch ? dwell_in_m1 : dwell_m1_q;
        dwell_dec   = (state == ST_SCAN) && !stop && !dwell_zero;

        gap_load    = advance && HAS_GAP;
        gap_dec     = (state == ST_GAP) && !gap_zero;
    end

    scan_down_counter #(.W(DWELL_W)) u_dwell_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (dwell_load),
        .load_val (dwell_val),
        .dec      (dwell_dec),
        .count    (dwell_cnt),
        .zero     (dwell_zero)
    );

    scan_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .count    (gap_cnt),
        .zero     (gap_zero)
    );

    // Scan FSM with latched configuration and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state updates use non-blocking assignments so every register
        // sees the values from before the clock edge.
        if (reset) begin
            state      <= ST_IDLE;
            last_q     <= '0;
            cont_q     <= 1'b0;
            dwell_m1_q <= '0;
            channel    <= '0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (stop && (state != ST_IDLE)) begin
            // Abort: back to idle with the select lines parked on channel 0.
            state   <= ST_IDLE;
            channel <= '0;
            enable  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (launch) begin
                        last_q     <= last_ch;
                        cont_q     <= continuous;
                        dwell_m1_q <= dwell_in_m1;
                        channel    <= '0;
                        enable     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (advance) begin
                        // Select lines move on gap entry so they settle while blanked.
                        channel <= next_ch;
                        if (HAS_GAP) begin
                            enable <= 1'b0;
                            state  <= ST_GAP;
                        end
                    end else if (dwell_end) begin
                        enable <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        enable <= 1'b1;
                        state  <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a = channel[0];
    assign b = channel[1];
    assign c = channel[2];

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer feeding a 3-to-8 decoder. Expected traces
// come from a sequence model: per channel, dwell cycles with enable high,
// gap cycles with enable low on the next channel, and a final done cycle.
module tb_decoder_scan_sequencer;

    localparam int DWELL_W = 8;
    localparam int G       = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic               continuous;
    logic [2:0]         last_ch;
    logic [DWELL_W-1:0] dwell;
    logic               a, b, c, enable, busy, done;
    logic [2:0]         channel;
    logic [7:0]         y;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       en;
        logic [2:0] ch;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        int last;
        int dw;
        bit cont;
        int exp_total;
    } vec_t;

    exp_t trace[$];
    vec_t vecs[6];

    decoder_scan_sequencer #(.DWELL_W(DWELL_W), .GAP_CYCLES(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .last_ch    (last_ch),
        .dwell      (dwell),
        .a          (a),
        .b          (b),
        .c          (c),
        .enable     (enable),
        .channel    (channel),
        .busy       (busy),
        .done       (done)
    );

    // 3-to-8 decoder downstream of the sequencer.
    assign y = enable ? (8'd1 << {c, b, a}) : 8'd0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle(input string name, input exp_t e);
        logic [31:0] act;
        logic [31:0] exp;
        logic [7:0]  onehot;
        onehot = e.en ? (8'd1 << e.ch) : 8'd0;
        act = {15'd0, y, enable, c, b, a, channel, busy, done};
        exp = {15'd0, onehot, e.en, e.ch, e.ch, e.busy, e.done};
        check(name, act, exp);
    endtask

    function automatic void build_trace(input int last, input int dw, input bit cont, input int min_len);
        int d;
        bit going;
        d = (dw == 0) ? 1 : dw;
        going = 1'b1;
        trace.delete();
        while (going) begin
            for (int ch = 0; ch <= last; ch++) begin
                for (int k = 0; k < d; k++)
                    trace.push_back(exp_t'{1'b1, 3'(ch), 1'b1, 1'b0});
                if (ch < last || cont)
                    for (int g = 0; g < G; g++)
                        trace.push_back(exp_t'{1'b0, (ch < last) ? 3'(ch + 1) : 3'd0, 1'b1, 1'b0});
            end
            if (!cont) begin
                trace.push_back(exp_t'{1'b0, 3'(last), 1'b0, 1'b1});
                going = 1'b0;
            end else if (trace.size() >= min_len) begin
                going = 1'b0;
            end
        end
    endfunction

    // Start one scan and follow it cycle by cycle against the model trace.
    task automatic run_trace(input string name, input int last, input int dw, input bit cont,
                             input int stop_at, input bit hold_start, input int exp_total,
                             input int min_len);
        int done_at;
        last_ch    = 3'(last);
        dwell      = DWELL_W'(dw);
        continuous = cont;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = hold_start;
        // Scrambled inputs must not disturb the latched configuration.
        last_ch    = 3'($urandom);
        dwell      = DWELL_W'($urandom);
        continuous = 1'($urandom);
        build_trace(last, dw, cont, min_len);
        done_at = -1;
        for (int i = 0; i < trace.size(); i++) begin
            compare_cycle(name, trace[i]);
            if (trace[i].done && done_at < 0) done_at = i;
            if (hold_start && trace[i].done) start = 1'b0;
            if (i == stop_at) begin
                stop = 1'b1;
                @(posedge clk); #1;
                stop = 1'b0;
                compare_cycle({name, "_stop"}, exp_t'{1'b0, 3'd0, 1'b0, 1'b0});
                start = 1'b0;
                return;
            end
            if (i < trace.size() - 1) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        if (cont) begin
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
            compare_cycle({name, "_stop"}, exp_t'{1'b0, 3'd0, 1'b0, 1'b0});
        end else begin
            @(posedge clk); #1;
            compare_cycle({name, "_idle"}, exp_t'{1'b0, 3'(last), 1'b0, 1'b0});
            if (exp_total > 0) check({name, "_cycles_to_done"}, 32'(done_at + 1), 32'(exp_total));
        end
    endtask

    initial begin
        vecs[0] = '{last: 2, dw: 3, cont: 1'b0, exp_total: 12};
        vecs[1] = '{last: 0, dw: 0, cont: 1'b0, exp_total: 2};
        vecs[2] = '{last: 7, dw: 1, cont: 1'b0, exp_total: 16};
        vecs[3] = '{last: 3, dw: 2, cont: 1'b0, exp_total: 12};
        vecs[4] = '{last: 1, dw: 5, cont: 1'b0, exp_total: 12};
        vecs[5] = '{last: 0, dw: 4, cont: 1'b0, exp_total: 5};

        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        last_ch    = 3'd0;
        dwell      = '0;
        #3;
        compare_cycle("reset_state", exp_t'{1'b0, 3'd0, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        compare_cycle("idle_after_reset", exp_t'{1'b0, 3'd0, 1'b0, 1'b0});

        // Table-driven single passes.
        for (int v = 0; v < 6; v++)
            run_trace($sformatf("vec%0d", v), vecs[v].last, vecs[v].dw, vecs[v].cont,
                      -1, 1'b0, vecs[v].exp_total, 0);

        // Stop during the second dwell cycle of channel 4, then restart.
        run_trace("stop_ch4", 7, 3, 1'b0, 17, 1'b0, 0, 0);
        run_trace("restart", 2, 3, 1'b0, -1, 1'b0, 12, 0);

        // start and stop together in idle: nothing happens.
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        compare_cycle("start_stop_idle", exp_t'{1'b0, 3'd2, 1'b0, 1'b0});
        @(posedge clk); #1;
        compare_cycle("start_stop_idle2", exp_t'{1'b0, 3'd2, 1'b0, 1'b0});

        // start held high for the whole scan.
        run_trace("held_start", 3, 2, 1'b0, -1, 1'b1, 12, 0);

        // Continuous scan over all eight channels.
        run_trace("continuous", 7, 1, 1'b1, -1, 1'b0, 0, 40);

        // Asynchronous reset in the middle of a gap.
        last_ch    = 3'd2;
        dwell      = DWELL_W'(2);
        continuous = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        compare_cycle("in_gap", exp_t'{1'b0, 3'd1, 1'b1, 1'b0});
        #2;
        reset = 1'b1;
        #1;
        compare_cycle("async_reset", exp_t'{1'b0, 3'd0, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        compare_cycle("after_reset_idle", exp_t'{1'b0, 3'd0, 1'b0, 1'b0});
        run_trace("post_reset", 2, 2, 1'b0, -1, 1'b0, 9, 0);

        // Random configurations with occasional aborts.
        for (int r = 0; r < 25; r++) begin
            int rl, rd, sa;
            bit rc;
            rl = int'($urandom_range(0, 7));
            rd = int'($urandom_range(0, 4));
            rc = ($urandom_range(0, 3) == 0);
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            run_trace($sformatf("rand%0d", r), rl, rd, rc, sa, 1'b0, 0, 24);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
